// File: rtl/life_pkg.sv
// Shared types for the 8x8 Game of Life generation controller.
package life_pkg;

  typedef logic [63:0] grid_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } seq_state_t;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    EXTINCT = 2'b01,
    STILL   = 2'b10,
    PERIOD2 = 2'b11
  } halt_cause_t;

endpackage

// File: rtl/life_tick_div.sv
// Generation-rate divider: counts 0..div and flags the terminal count.
// A count above div (div lowered mid-run) wraps through 2^DIV_W back to 0.
module life_tick_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  assign tick = (count == div);

  // Divider counter: cleared when not free-running, restarts after each tick.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/life_sequencer.sv
// Generation controller for the 8x8 Game of Life engine.
// Owns the current grid, steps it from the external next-state datapath
// (free-running or single-step) and halts on extinction, still life and,
// when LIFE_PERIOD2_DETECT_EN is defined, period-2 oscillation.
module life_sequencer
  import life_pkg::*;
#(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned GEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      seed,
  input  logic             load,
  input  logic             run,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  input  logic [63:0]      next_grid,
  output logic [63:0]      grid,
  output logic [GEN_W-1:0] gen_count,
  output logic             update,
  output logic             halted,
  output logic [1:0]       halt_cause
);

  seq_state_t       state;
  seq_state_t       state_next;
  grid_t            grid_q;
  logic [GEN_W-1:0] gen_q;
  logic             update_q;
  halt_cause_t      cause_q;
  halt_cause_t      cause_next;

  logic             tick;
  logic             tick_clear;
  logic             do_eval;
  logic             commit;
  logic             halt_go;

`ifdef LIFE_PERIOD2_DETECT_EN
  grid_t            prev_q;
`endif

  life_tick_div #(
    .DIV_W(DIV_W)
  ) u_tick_div (
    .clk  (clk),
    .reset(reset),
    .clear(tick_clear),
    .div  (div),
    .tick (tick)
  );

  // Next state, divider control and evaluate decision (load > run > step).
  always_comb begin
    state_next = state;
    do_eval    = 1'b0;
    tick_clear = 1'b1;
    cause_next = NONE;
    halt_go    = 1'b0;
    commit     = 1'b0;

    if (load) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state_next = RUN;
          end else if (step) begin
            do_eval = 1'b1;
          end
        end
        RUN: begin
          if (!run) begin
            state_next = IDLE;
          end else begin
            tick_clear = 1'b0;
            do_eval    = tick;
          end
        end
        HALT: begin
          state_next = HALT;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    if (do_eval) begin
      if (grid_q == '0) begin
        halt_go    = 1'b1;
        cause_next = EXTINCT;
      end else if (next_grid == grid_q) begin
        halt_go    = 1'b1;
        cause_next = STILL;
`ifdef LIFE_PERIOD2_DETECT_EN
      end else if (next_grid == prev_q) begin
        halt_go    = 1'b1;
        cause_next = PERIOD2;
`endif
      end else begin
        commit = 1'b1;
      end
    end

    if (halt_go) begin
      state_next = HALT;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grid, generation counter, update pulse and halt cause.
  always_ff @(posedge clk) begin
    if (reset) begin
      grid_q   <= '0;
      gen_q    <= '0;
      update_q <= 1'b0;
      cause_q  <= NONE;
    end else begin
      update_q <= 1'b0;
      if (load) begin
        grid_q  <= seed;
        gen_q   <= '0;
        cause_q <= NONE;
      end else if (commit) begin
        grid_q   <= next_grid;
        update_q <= 1'b1;
        if (gen_q != '1) begin
          gen_q <= gen_q + 1'b1;
        end
      end else if (halt_go) begin
        cause_q <= cause_next;
      end
    end
  end

`ifdef LIFE_PERIOD2_DETECT_EN
  // Previous generation, used only by the period-2 check.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
    end else if (load) begin
      prev_q <= seed;
    end else if (commit) begin
      prev_q <= grid_q;
    end
  end
`endif

  assign grid       = grid_q;
  assign gen_count  = gen_q;
  assign update     = update_q;
  assign halted     = (state == HALT);
  assign halt_cause = cause_q;

endmodule
